// File: rtl/fadd_issuer.sv
// fadd_issuer
//   Issues single-precision add/subtract requests to a fixed-latency fadd
//   unit (which always computes op1 - op2) and returns results in order
//   through a credit-protected response FIFO.
//
// Parameters
//   LAT   : fadd edges from operands stable to result stable
//   DEPTH : response FIFO entries = maximum outstanding operations
//   TAGW  : request tag width
//
// Ports
//   clk, reset (async, active-low)
//   req_valid/req_ready, req_op1, req_op2, req_sub, req_tag : request side
//   fadd_op1, fadd_op2      : registered operands to the fadd unit
//   fadd_result, fadd_valid : fadd result and no-underflow flag
//   fadd_ready              : present on the fadd interface, not used
//   resp_valid/resp_ready, resp_result, resp_tag, resp_uflow : response side
module fadd_issuer #(
  parameter int LAT   = 3,
  parameter int DEPTH = 4,
  parameter int TAGW  = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [31:0]     req_op1,
  input  logic [31:0]     req_op2,
  input  logic            req_sub,
  input  logic [TAGW-1:0] req_tag,
  output logic [31:0]     fadd_op1,
  output logic [31:0]     fadd_op2,
  input  logic [31:0]     fadd_result,
  input  logic            fadd_valid,
  input  logic            fadd_ready,
  output logic            resp_valid,
  input  logic            resp_ready,
  output logic [31:0]     resp_result,
  output logic [TAGW-1:0] resp_tag,
  output logic            resp_uflow
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int EW = 32 + 1 + TAGW;

  // The fadd unit only subtracts, so an add is issued as op1 - (-op2).
  function automatic logic [31:0] prep_op2(input logic [31:0] op2, input logic sub);
    return sub ? op2 : {~op2[31], op2[30:0]};
  endfunction

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  logic unused_fadd_ready;
  assign unused_fadd_ready = fadd_ready;

  logic            accept;
  logic            capture;
  logic            pop;
  logic [LAT:0]    vld_p;
  logic [TAGW-1:0] tag_p [LAT+1];
  logic [CW-1:0]   inflight_cnt;
  logic [CW-1:0]   fifo_cnt;
  logic [CW-1:0]   inflight_nxt;
  logic [CW-1:0]   fifo_nxt;
  logic [CW:0]     occ_nxt;
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;
  logic [EW-1:0]   mem [DEPTH];
  logic [EW-1:0]   head;
  logic [EW-1:0]   last_q;

  assign accept  = req_valid & req_ready;
  // The last in-flight stage lines up with the edge at which the fadd
  // result for that operation is stable.
  assign capture = vld_p[LAT];
  assign pop     = resp_valid & resp_ready;

  // Stage 0: operand register feeding the fadd unit
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fadd_op1 <= '0;
      fadd_op2 <= '0;
    end else if (accept) begin
      fadd_op1 <= req_op1;
      fadd_op2 <= prep_op2(req_op2, req_sub);
    end
  end

  // Stages 0..LAT: in-flight valid/tag shadow of the fadd pipeline
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      vld_p <= '0;
    end else begin
      vld_p <= {vld_p[LAT-1:0], accept};
    end
  end

  always_ff @(posedge clk) begin
    tag_p[0] <= req_tag;
    for (int i = 1; i <= LAT; i++) begin
      tag_p[i] <= tag_p[i-1];
    end
  end

  always_comb begin
    inflight_nxt = inflight_cnt;
    fifo_nxt     = fifo_cnt;
    if (accept && !capture) begin
      inflight_nxt = inflight_cnt + CW'(1);
    end else if (!accept && capture) begin
      inflight_nxt = inflight_cnt - CW'(1);
    end
    if (capture && !pop) begin
      fifo_nxt = fifo_cnt + CW'(1);
    end else if (!capture && pop) begin
      fifo_nxt = fifo_cnt - CW'(1);
    end
    occ_nxt = {1'b0, inflight_nxt} + {1'b0, fifo_nxt};
  end

  // Stage LAT+1: capture into the response FIFO, credit update
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      inflight_cnt <= '0;
      fifo_cnt     <= '0;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      req_ready    <= 1'b0;
    end else begin
      inflight_cnt <= inflight_nxt;
      fifo_cnt     <= fifo_nxt;
      // Registered from the next-state counts: a pop frees credit only
      // from the following cycle, and req_ready stays low in reset.
      req_ready    <= (occ_nxt < (CW+1)'(DEPTH));
      if (capture) begin
        wr_ptr <= next_ptr(wr_ptr);
      end
      if (pop) begin
        rd_ptr <= next_ptr(rd_ptr);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (capture) begin
      mem[wr_ptr] <= {fadd_result, ~fadd_valid, tag_p[LAT]};
    end
    if (pop) begin
      last_q <= mem[rd_ptr];
    end
  end

  // When empty, present the most recently popped entry so resp_* hold.
  assign resp_valid  = (fifo_cnt != '0);
  assign head        = resp_valid ? mem[rd_ptr] : last_q;
  assign resp_result = head[EW-1 -: 32];
  assign resp_uflow  = head[TAGW];
  assign resp_tag    = head[TAGW-1:0];

endmodule

// File: tb/tb_fadd_issuer.sv
// tb_fadd_issuer
//   Directed and randomized bench for fadd_issuer. The bench plays the fadd
//   unit (a LAT-deep pipeline of a stand-in function) and keeps a
//   request-level scoreboard: every outstanding operation is a queue entry
//   with the edge at which it becomes visible; credit is queue size < DEPTH.
module tb_fadd_issuer;

  localparam int LAT   = 3;
  localparam int DEPTH = 4;
  localparam int TAGW  = 4;

  logic            clk = 1'b0;
  logic            reset;
  logic            req_valid;
  logic            req_ready;
  logic [31:0]     req_op1;
  logic [31:0]     req_op2;
  logic            req_sub;
  logic [TAGW-1:0] req_tag;
  logic [31:0]     fadd_op1;
  logic [31:0]     fadd_op2;
  logic [31:0]     fadd_result;
  logic            fadd_valid;
  logic            fadd_ready;
  logic            resp_valid;
  logic            resp_ready;
  logic [31:0]     resp_result;
  logic [TAGW-1:0] resp_tag;
  logic            resp_uflow;

  fadd_issuer #(.LAT(LAT), .DEPTH(DEPTH), .TAGW(TAGW)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_op1(req_op1), .req_op2(req_op2), .req_sub(req_sub), .req_tag(req_tag),
    .fadd_op1(fadd_op1), .fadd_op2(fadd_op2),
    .fadd_result(fadd_result), .fadd_valid(fadd_valid), .fadd_ready(fadd_ready),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_result(resp_result), .resp_tag(resp_tag), .resp_uflow(resp_uflow)
  );

  always #5 clk = ~clk;

  // Stand-in fadd arithmetic: exact for the directed operand pairs,
  // an opaque mix otherwise.
  function automatic logic [31:0] fmodel(input logic [31:0] a, input logic [31:0] b);
    if (a == 32'h3F80_0000 && b == 32'hC000_0000) return 32'h4040_0000;
    if (a == 32'h4040_0000 && b == 32'h3F80_0000) return 32'h4000_0000;
    return a ^ {b[15:0], b[31:16]} ^ 32'h5A5A_0000;
  endfunction

  function automatic logic fuf(input logic [31:0] a);
    return (a[3:0] == 4'hF);
  endfunction

  logic [31:0] fp_res [LAT];
  logic        fp_uf  [LAT];
  always @(posedge clk) begin
    fp_res[0] <= fmodel(fadd_op1, fadd_op2);
    fp_uf[0]  <= fuf(fadd_op1);
    for (int i = 1; i < LAT; i++) begin
      fp_res[i] <= fp_res[i-1];
      fp_uf[i]  <= fp_uf[i-1];
    end
  end
  assign fadd_result = fp_res[LAT-1];
  assign fadd_valid  = ~fp_uf[LAT-1];
  assign fadd_ready  = 1'b1;

  typedef struct {
    logic [31:0]     res;
    logic [TAGW-1:0] tag;
    logic            uf;
    int              avail;
  } ent_t;

  ent_t            sb[$];
  int              total = 0;
  int              bad   = 0;
  int              ncyc  = 0;
  logic            rst_hold = 1'b1;
  logic [31:0]     exp_op1 = '0;
  logic [31:0]     exp_op2 = '0;
  logic            have_last = 1'b0;
  logic [31:0]     last_res;
  logic [TAGW-1:0] last_tag;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock cycle: check outputs against the model, take the edge,
  // update the model, check the operand register.
  task automatic cyc(output logic acc);
    logic exp_rdy, exp_vld, pop;
    exp_rdy = !rst_hold && (sb.size() < DEPTH);
    exp_vld = 1'b0;
    if (sb.size() > 0) exp_vld = (ncyc >= sb[0].avail);
    chk("req_ready", {31'b0, req_ready}, {31'b0, exp_rdy});
    chk("resp_valid", {31'b0, resp_valid}, {31'b0, exp_vld});
    if (exp_vld) begin
      chk("resp_result", resp_result, sb[0].res);
      chk("resp_tag", 32'(resp_tag), 32'(sb[0].tag));
      chk("resp_uflow", {31'b0, resp_uflow}, {31'b0, sb[0].uf});
    end else if (have_last) begin
      chk("hold_result", resp_result, last_res);
      chk("hold_tag", 32'(resp_tag), 32'(last_tag));
    end
    acc = req_valid && exp_rdy;
    pop = exp_vld && resp_ready;
    @(posedge clk);
    ncyc++;
    if (pop) begin
      last_res  = sb[0].res;
      last_tag  = sb[0].tag;
      have_last = 1'b1;
      void'(sb.pop_front());
    end
    if (acc) begin
      ent_t e;
      exp_op1 = req_op1;
      exp_op2 = req_sub ? req_op2 : (req_op2 ^ 32'h8000_0000);
      e.res   = fmodel(exp_op1, exp_op2);
      e.tag   = req_tag;
      e.uf    = fuf(req_op1);
      e.avail = ncyc + LAT + 1;
      sb.push_back(e);
    end
    if (reset) rst_hold = 1'b0;
    #1;
    chk("fadd_op1", fadd_op1, exp_op1);
    chk("fadd_op2", fadd_op2, exp_op2);
  endtask

  task automatic idle(input int n, input logic rr);
    logic a;
    req_valid  = 1'b0;
    resp_ready = rr;
    for (int i = 0; i < n; i++) cyc(a);
  endtask

  task automatic issue(input logic [31:0] o1, input logic [31:0] o2, input logic s,
                       input logic [TAGW-1:0] t, input logic rr, output logic acc);
    req_valid  = 1'b1;
    req_op1    = o1;
    req_op2    = o2;
    req_sub    = s;
    req_tag    = t;
    resp_ready = rr;
    cyc(acc);
    req_valid  = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic a;
    int   n_acc;
    reset      = 1'b1;
    req_valid  = 1'b0;
    req_op1    = '0;
    req_op2    = '0;
    req_sub    = 1'b0;
    req_tag    = '0;
    resp_ready = 1'b0;
    #2 reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_req_ready", {31'b0, req_ready}, 32'd0);
    chk("rst_resp_valid", {31'b0, resp_valid}, 32'd0);
    chk("rst_fadd_op1", fadd_op1, 32'd0);
    chk("rst_fadd_op2", fadd_op2, 32'd0);
    @(negedge clk) reset = 1'b1;

    // Add 1.0 + 2.0
    idle(1, 1'b0);
    issue(32'h3F80_0000, 32'h4000_0000, 1'b0, 4'd5, 1'b0, a);
    chk("add_accept", {31'b0, a}, 32'd1);
    chk("add_fadd_op2", fadd_op2, 32'hC000_0000);
    idle(LAT, 1'b0);
    chk("add_not_early", {31'b0, resp_valid}, 32'd0);
    idle(1, 1'b0);
    chk("add_valid", {31'b0, resp_valid}, 32'd1);
    chk("add_result", resp_result, 32'h4040_0000);
    chk("add_tag", 32'(resp_tag), 32'd5);
    chk("add_uflow", {31'b0, resp_uflow}, 32'd0);
    idle(3, 1'b1);

    // Subtract 3.0 - 1.0
    issue(32'h4040_0000, 32'h3F80_0000, 1'b1, 4'd7, 1'b0, a);
    chk("sub_fadd_op2", fadd_op2, 32'h3F80_0000);
    idle(LAT + 1, 1'b0);
    chk("sub_result", resp_result, 32'h4000_0000);
    idle(3, 1'b1);

    // Backpressure: fill all credit, single pop, drain
    for (int t = 0; t < 4; t++) begin
      issue($urandom, $urandom, 1'($urandom), TAGW'(t), 1'b0, a);
      chk("bp_accept", {31'b0, a}, 32'd1);
    end
    chk("bp_full", {31'b0, req_ready}, 32'd0);
    idle(LAT + 2, 1'b0);
    chk("bp_head_tag", 32'(resp_tag), 32'd0);
    idle(1, 1'b1);
    chk("bp_credit_back", {31'b0, req_ready}, 32'd1);
    idle(6, 1'b1);

    // Streaming
    n_acc = 0;
    for (int i = 0; i < 40 && n_acc < 8; i++) begin
      issue($urandom, $urandom, 1'($urandom), TAGW'(n_acc), 1'b1, a);
      if (a) n_acc++;
    end
    chk("stream_accepts", n_acc, 32'd8);
    idle(LAT + 4, 1'b1);

    // Underflow
    issue(32'h3F80_000F, 32'h3F80_0000, 1'b1, 4'd9, 1'b0, a);
    idle(LAT + 1, 1'b0);
    chk("uf_flag", {31'b0, resp_uflow}, 32'd1);
    chk("uf_tag", 32'(resp_tag), 32'd9);
    idle(3, 1'b1);

    // Randomized traffic
    for (int i = 0; i < 300; i++) begin
      req_valid  = ($urandom_range(0, 9) < 7);
      req_op1    = $urandom;
      req_op2    = $urandom;
      req_sub    = 1'($urandom);
      req_tag    = TAGW'($urandom);
      resp_ready = ($urandom_range(0, 9) < 6);
      cyc(a);
    end
    idle(LAT + 6, 1'b1);

    // Reset with two in flight and one queued
    issue(32'h1111_1110, 32'h2222_2222, 1'b0, 4'd1, 1'b0, a);
    idle(1, 1'b0);
    issue(32'h3333_3330, 32'h4444_4444, 1'b1, 4'd2, 1'b0, a);
    issue(32'h5555_5550, 32'h6666_6666, 1'b0, 4'd3, 1'b0, a);
    idle(1, 1'b0);
    chk("pre_rst_valid", {31'b0, resp_valid}, 32'd1);
    #2 reset = 1'b0;
    #1;
    chk("mid_rst_valid", {31'b0, resp_valid}, 32'd0);
    chk("mid_rst_ready", {31'b0, req_ready}, 32'd0);
    chk("mid_rst_op1", fadd_op1, 32'd0);
    chk("mid_rst_op2", fadd_op2, 32'd0);
    sb.delete();
    exp_op1  = '0;
    exp_op2  = '0;
    rst_hold = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk) reset = 1'b1;
    idle(12, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fadd_issuer.md
FADD_ISSUER -- requirements
Module: fadd_issuer

Interface
REQ-001 Parameter LAT, default 3: fadd clock edges from operands stable at its inputs to result stable at its outputs.
REQ-002 Parameter DEPTH, default 4: response FIFO entries, which is also the maximum number of outstanding operations.
REQ-003 Parameter TAGW, default 4: request tag width.
REQ-004 clk  in  1  single clock; all state on posedge.
REQ-005 reset  in  1  asynchronous, active-low reset.
REQ-006 req_valid  in  1  request present.
REQ-007 req_ready  out  1  request accepted this cycle when high with req_valid.
REQ-008 req_op1, req_op2  in  32 each  IEEE-754 single operands.
REQ-009 req_sub  in  1  1 = op1-op2; 0 = op1+op2.
REQ-010 req_tag  in  TAGW  opaque tag returned with the result.
REQ-011 fadd_op1, fadd_op2  out  32 each  operands driven to the fadd unit (which computes op1 minus op2).
REQ-012 fadd_result  in  32  fadd result.
REQ-013 fadd_valid  in  1  fadd no-underflow flag (0 = underflow).
REQ-014 fadd_ready  in  1  fadd ready; not used for sequencing.
REQ-015 resp_valid  out  1  response available.
REQ-016 resp_ready  in  1  consumer accepts the response.
REQ-017 resp_result  out  32  sum/difference.
REQ-018 resp_tag  out  TAGW  tag of the request.
REQ-019 resp_uflow  out  1  1 when fadd_valid was 0 at capture.

Function
REQ-020 Accept: req_valid & req_ready at edge E0 registers fadd_op1=req_op1, fadd_op2=req_op2 with bit31 inverted when req_sub=0 and unchanged when req_sub=1.
REQ-021 fadd_op1/fadd_op2 hold their last value when no request is accepted.
REQ-022 In-flight tracking: a LAT+1-stage shift register of {valid, tag} advances every cycle and is loaded at E0.
REQ-023 Capture: at edge E0+LAT+1, {fadd_result, ~fadd_valid, tag} is pushed into the FIFO; back-to-back accepts yield back-to-back captures in order.
REQ-024 Minimum latency: resp_valid rises in the cycle following edge E0+LAT+1 (LAT+2 edges after accept); responses leave in acceptance order.
REQ-025 FIFO: circular, DEPTH entries, pointers wrap modulo DEPTH; resp_* reflect the head entry; pop on resp_valid & resp_ready.
REQ-026 Credit: req_ready = (inflight_count + fifo_count) < DEPTH, both counts registered; no same-cycle bypass of a pop into req_ready.
REQ-027 The FIFO never overflows because of REQ-026; a simultaneous push and pop leaves fifo_count unchanged.
REQ-028 Simultaneous accept and capture: inflight_count is unchanged; accept with no capture: +1; capture with no accept: -1.
REQ-029 resp_valid is stable until popped and resp_* do not change while resp_valid=1 and resp_ready=0.
REQ-030 Empty FIFO: resp_valid=0 and resp_* hold their last value.

Reset
REQ-031 reset low clears immediately, without waiting for clk, all of: stage valids, counts, pointers, resp_valid, req_ready, fadd_op1, fadd_op2 (all 0).
REQ-032 Operations in flight or queued at reset are discarded and never produce a response.
REQ-033 Post-reset: req_ready goes to 1 at the first edge with reset high; stale fadd outputs during that time are not captured.

Verification
REQ-034 Add: op1=0x3F800000, op2=0x40000000, sub=0, tag=5 -> fadd_op2=0xC0000000; after LAT+2 edges resp_result=0x40400000, tag=5, uflow=0.
REQ-035 Subtract: op1=0x40400000, op2=0x3F800000, sub=1 -> fadd_op2=0x3F800000; resp_result=0x40000000.
REQ-036 Backpressure: resp_ready=0, four back-to-back accepts (tags 0-3) -> req_ready=0 after the 4th accept; pulsing resp_ready for one cycle pops tag 0 and req_ready=1 on the next cycle; tags then drain in order 1,2,3.
REQ-037 Streaming: resp_ready=1, eight consecutive requests -> eight responses on consecutive cycles, in order, with no req_ready drop beyond credit.
REQ-038 Underflow: fadd model drives fadd_valid=0 on the capture edge -> resp_uflow=1 with the matching tag.
REQ-039 Reset mid-operation: assert reset with 2 in flight and 1 queued -> resp_valid=0 immediately; after release no response appears within 10 cycles.
